// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned AddrWDefault = 5;
  localparam int unsigned DataWDefault = 32;

  // Encoding of the round-robin pointer / most recent grant.
  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic                    valid;
    logic [AddrWDefault-1:0] addr;
    logic [DataWDefault-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback requester, reservation and register-file write signals.
interface regfile_write_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic                     a_valid;
  logic [ADDR_W-1:0]        a_addr;
  logic [DATA_W-1:0]        a_data;
  logic                     a_ready;
  logic                     b_valid;
  logic [ADDR_W-1:0]        b_addr;
  logic [DATA_W-1:0]        b_data;
  logic                     b_ready;
  logic                     res_valid;
  logic [ADDR_W-1:0]        res_addr;
  logic                     en_wri;
  logic [ADDR_W-1:0]        wri_add;
  logic [DATA_W-1:0]        wr_data;
  logic [(1<<ADDR_W)-1:0]   busy;
  logic                     last_grant;

  // Requesters, issue stage and register-file side.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, res_valid, res_addr,
    input  a_ready, b_ready, en_wri, wri_add, wr_data, busy, last_grant
  );

  // The arbiter itself.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, res_valid, res_addr,
    output a_ready, b_ready, en_wri, wri_add, wr_data, busy, last_grant
  );

endinterface

// File: rtl/regfile_write_arbiter_rf_scoreboard.sv
// Per-register busy scoreboard: a reservation sets a bit, a committed write
// clears it; a set and clear of the same register on one edge leaves it set.
module regfile_write_arbiter_rf_scoreboard
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   set_i,
  input  logic [ADDR_W-1:0]      set_addr_i,
  input  logic                   clr_i,
  input  logic [ADDR_W-1:0]      clr_addr_i,
  output logic [(1<<ADDR_W)-1:0] busy_o
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [NumRegs-1:0] busy_d, busy_q;

  // Next busy vector: clear first, then set, so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (A) and load (B)
// writeback paths, registers the selected write and tracks busy registers.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter bit          DROP_R0    = 1'b1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  regfile_write_arbiter_if.slave  wb_io
);

  wb_req_t req_a, req_b, req_sel;

  logic              grant_a, grant_b, granted, fwd, res_set;
  logic              last_grant_d, last_grant_q;
  logic              en_d, en_q;
  logic [ADDR_W-1:0] wri_add_d, wri_add_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Gather the two requesters into request structs.
  always_comb begin
    req_a = '{valid: wb_io.a_valid, addr: wb_io.a_addr, data: wb_io.a_data};
    req_b = '{valid: wb_io.b_valid, addr: wb_io.b_addr, data: wb_io.b_data};
  end

  // Grant selection; no grants are issued while reset is asserted.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_ni) begin
      if (req_a.valid && req_b.valid) begin
        if (FIXED_PRIO || (last_grant_q == GRANT_A)) grant_b = 1'b1;
        else                                         grant_a = 1'b1;
      end else begin
        grant_a = req_a.valid;
        grant_b = req_b.valid;
      end
    end
  end

  // Next-state for the pointer and the output write stage.
  always_comb begin
    req_sel      = grant_b ? req_b : req_a;
    granted      = grant_a | grant_b;
    // Writes to r0 are accepted but swallowed when DROP_R0 is set.
    fwd          = granted && !(DROP_R0 && (req_sel.addr == '0));
    last_grant_d = last_grant_q;
    if (granted) last_grant_d = grant_b ? GRANT_B : GRANT_A;
    en_d      = fwd;
    wri_add_d = fwd ? req_sel.addr : wri_add_q;
    data_d    = fwd ? req_sel.data : data_q;
  end

  // Round-robin pointer and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= GRANT_B;
      en_q         <= 1'b0;
      wri_add_q    <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      en_q         <= en_d;
      wri_add_q    <= wri_add_d;
      data_q       <= data_d;
    end
  end

  assign res_set = wb_io.res_valid && !(DROP_R0 && (wb_io.res_addr == '0));

  // The committing write (en_q) clears its register on the edge the file is written.
  regfile_write_arbiter_rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (res_set),
    .set_addr_i (wb_io.res_addr),
    .clr_i      (en_q),
    .clr_addr_i (wri_add_q),
    .busy_o     (wb_io.busy)
  );

  assign wb_io.a_ready    = grant_a;
  assign wb_io.b_ready    = grant_b;
  assign wb_io.en_wri     = en_q;
  assign wb_io.wri_add    = wri_add_q;
  assign wb_io.wr_data    = data_q;
  assign wb_io.last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Drives a round-robin/drop-r0 instance and a fixed-priority/keep-r0 instance
// with identical stimulus and compares both against a transaction-level model.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, b_valid = 1'b0, res_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0, res_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rr_if ();
  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) fp_if ();

  assign rr_if.a_valid = a_valid;  assign fp_if.a_valid = a_valid;
  assign rr_if.a_addr  = a_addr;   assign fp_if.a_addr  = a_addr;
  assign rr_if.a_data  = a_data;   assign fp_if.a_data  = a_data;
  assign rr_if.b_valid = b_valid;  assign fp_if.b_valid = b_valid;
  assign rr_if.b_addr  = b_addr;   assign fp_if.b_addr  = b_addr;
  assign rr_if.b_data  = b_data;   assign fp_if.b_data  = b_data;
  assign rr_if.res_valid = res_valid;  assign fp_if.res_valid = res_valid;
  assign rr_if.res_addr  = res_addr;   assign fp_if.res_addr  = res_addr;

  regfile_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b0), .DROP_R0(1'b1)
  ) u_rr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb_io  (rr_if)
  );

  regfile_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1'b1), .DROP_R0(1'b0)
  ) u_fp (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb_io  (fp_if)
  );

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic        a_ready_w[2], b_ready_w[2], en_w[2], last_w[2];
  logic [4:0]  add_w[2];
  logic [31:0] data_w[2], busy_w[2];

  assign a_ready_w[0] = rr_if.a_ready;  assign a_ready_w[1] = fp_if.a_ready;
  assign b_ready_w[0] = rr_if.b_ready;  assign b_ready_w[1] = fp_if.b_ready;
  assign en_w[0]      = rr_if.en_wri;   assign en_w[1]      = fp_if.en_wri;
  assign add_w[0]     = rr_if.wri_add;  assign add_w[1]     = fp_if.wri_add;
  assign data_w[0]    = rr_if.wr_data;  assign data_w[1]    = fp_if.wr_data;
  assign busy_w[0]    = rr_if.busy;     assign busy_w[1]    = fp_if.busy;
  assign last_w[0]    = rr_if.last_grant;  assign last_w[1] = fp_if.last_grant;

  // Reference model state per instance.
  int          cfg_fixed[2] = '{0, 1};
  int          cfg_drop[2]  = '{1, 0};
  int          m_last[2];
  int          m_en[2];
  int          m_addr[2];
  int          m_data[2];
  logic [31:0] m_busy[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 1;
      m_en[d]   = 0;
      m_addr[d] = 0;
      m_data[d] = 0;
      m_busy[d] = '0;
    end
  endfunction

  // -1 = nobody, 0 = A, 1 = B.
  function automatic int winner(int d);
    if (a_valid && b_valid) return (cfg_fixed[d] != 0) ? 1 : 1 - m_last[d];
    if (a_valid) return 0;
    if (b_valid) return 1;
    return -1;
  endfunction

  function automatic void model_edge(int d);
    int w;
    int addr;
    w = winner(d);
    if (m_en[d] != 0) m_busy[d][m_addr[d]] = 1'b0;
    if (res_valid && !(cfg_drop[d] != 0 && res_addr == 0)) m_busy[d][res_addr] = 1'b1;
    m_en[d] = 0;
    if (w >= 0) begin
      m_last[d] = w;
      addr = (w == 1) ? int'(b_addr) : int'(a_addr);
      if (!(cfg_drop[d] != 0 && addr == 0)) begin
        m_en[d]   = 1;
        m_addr[d] = addr;
        m_data[d] = (w == 1) ? int'(b_data) : int'(a_data);
      end
    end
  endfunction

  // Inputs are already applied; check handshake, clock, check write stage.
  task automatic step(input string tag);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s%0d/a_ready", tag, d), 64'(a_ready_w[d]), 64'(winner(d) == 0));
      check_eq($sformatf("%s%0d/b_ready", tag, d), 64'(b_ready_w[d]), 64'(winner(d) == 1));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s%0d/en", tag, d), 64'(en_w[d]), 64'(m_en[d]));
      if (m_en[d] != 0) begin
        check_eq($sformatf("%s%0d/addr", tag, d), 64'(add_w[d]), 64'(m_addr[d]));
        check_eq($sformatf("%s%0d/data", tag, d), 64'(data_w[d]), 64'(unsigned'(m_data[d])));
      end
      check_eq($sformatf("%s%0d/busy", tag, d), 64'(busy_w[d]), 64'(m_busy[d]));
      check_eq($sformatf("%s%0d/last", tag, d), 64'(last_w[d]), 64'(m_last[d]));
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s%0d/en", tag, d), 64'(en_w[d]), 64'd0);
      check_eq($sformatf("%s%0d/addr", tag, d), 64'(add_w[d]), 64'd0);
      check_eq($sformatf("%s%0d/data", tag, d), 64'(data_w[d]), 64'd0);
      check_eq($sformatf("%s%0d/busy", tag, d), 64'(busy_w[d]), 64'd0);
      check_eq($sformatf("%s%0d/last", tag, d), 64'(last_w[d]), 64'd1);
      check_eq($sformatf("%s%0d/a_ready", tag, d), 64'(a_ready_w[d]), 64'd0);
      check_eq($sformatf("%s%0d/b_ready", tag, d), 64'(b_ready_w[d]), 64'd0);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  initial begin
    // Reset state with requests pending: no grants may leak out.
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    idle();
    model_reset();

    // Contention from reset: round-robin alternates starting with A.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1111_0005;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h2222_0006;
    for (int i = 0; i < 4; i++) begin
      a_data = a_data + 1;
      b_data = b_data + 1;
      step("both");
    end
    idle();
    step("both_end");

    // Single A write.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD_BEEF;
    step("a_only");
    idle();
    step("a_only_idle");

    // Reserve r7, then B writes it back and clears the bit.
    res_valid = 1'b1; res_addr = 5'd7;
    step("res7");
    idle();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0777;
    step("b7_grant");
    idle();
    step("b7_commit");
    step("b7_after");

    // Reservation on the same edge as the commit to r7: bit stays set.
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_7777;
    step("b7_again");
    idle();
    res_valid = 1'b1; res_addr = 5'd7;
    step("res_vs_clr");
    idle();
    step("res_vs_clr_hold");

    // r0 handling differs between the two instances.
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hCAFE_0000;
    step("r0_write");
    idle();
    step("r0_idle");
    res_valid = 1'b1; res_addr = 5'd0;
    step("r0_res");
    idle();
    step("r0_res_idle");

    // Random traffic biased toward low registers and contention.
    for (int i = 0; i < 400; i++) begin
      a_valid   = 1'($urandom_range(0, 1));
      b_valid   = 1'($urandom_range(0, 1));
      res_valid = ($urandom_range(0, 2) == 0);
      a_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      b_addr    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      res_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a_data    = $urandom;
      b_data    = $urandom;
      step("rand");
    end

    // Reset in the middle of a write: everything clears before the next edge.
    idle();
    res_valid = 1'b1; res_addr = 5'd12;
    step("pre_rst_res");
    idle();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0BAD_F00D;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h0BAD_F00E;
    step("pre_rst_wr");
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    model_reset();
    step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
